pipe_reg_de_elastic: RTL and testbench
======================================

Name: pipe_reg_de_elastic

Overview:
Parametrised Decode→Execute pipeline register with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush. It carries the full DE bundle (RD1, RD2, PC, ImmExt, PCPlus4, Rd, control word) between decode and execute. It lets either stage stall without combinational ready paths crossing the stage, and lets the branch unit squash in-flight instructions.

Parameters:
DATA_WIDTH, 32, width of RD1/RD2/PC/ImmExt/PCPlus4 fields
ADDR_WIDTH, 5, width of destination register index Rd
CTRL_WIDTH, 16, width of opaque decoded control word (ALUControl, RegWrite, MemWrite, etc.)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries (branch/jump taken)
in_valid  in  1  decode presents a valid bundle
in_ready  out  1  stage can accept; registered, equals "skid entry empty"
RD1D, RD2D, PCD, ImmExtD, PCPlus4D  in  DATA_WIDTH each  decode payload
RdD  in  ADDR_WIDTH  destination register
CtrlD  in  CTRL_WIDTH  control word
out_valid  out  1  execute-side bundle valid
out_ready  in  1  execute can consume this cycle
RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  DATA_WIDTH each  execute payload
RdE  out  ADDR_WIDTH  destination register; forced 0 when out_valid=0
CtrlE  out  CTRL_WIDTH  control word; forced 0 when out_valid=0

Behaviour:
- Reset (rst_n=0, async): state EMPTY, main and skid entries cleared. out_valid=0, in_ready=1, all payload outputs 0.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs are driven directly from the main entry register. in_ready is a flop (=!skid_valid). There is no combinational path from out_ready to in_ready.
- States:
  - EMPTY (main empty, skid empty)
  - FULL (main valid, skid empty)
  - SKID (both valid)
- Transitions, when flush=0:
  - EMPTY: in_fire → FULL, main<=in.
  - FULL: in_fire & out_fire → FULL, main<=in. in_fire & !out_ready → SKID, skid<=in. !in_fire & out_fire → EMPTY. Otherwise hold.
  - SKID: in_ready=0, so in_fire is impossible. out_fire → FULL, main<=skid. Otherwise hold.
- Latency: a bundle accepted at edge N appears on the outputs after edge N; with out_ready=1 it is consumed at edge N+1. Throughput is one per cycle when out_ready stays high.
- Ordering: strict FIFO. The skid entry is never bypassed by a newer input.
- Flush (priority over everything): at the next edge, state becomes EMPTY and both entries are invalidated. An input fired in the flush cycle is dropped. out_fire in the flush cycle still counts as consumed (execute has already sampled it). After the flush edge: in_ready=1, out_valid=0.
- Bubble rule: when out_valid=0, RdE=0 and CtrlE=0, so the hazard unit sees no dependency and no write-enable. Data fields RD1E/RD2E/PCE/ImmExtE/PCPlus4E are don't-care when invalid but must not be X after reset.
- Payload is never modified; field widths pass straight through. No arithmetic is performed.
- Async reset asserted mid-operation discards all entries immediately, independent of clk.
- Assertions to provide: SKID never entered with out_ready=1; in_fire never occurs in SKID; out_valid never drops without out_fire or flush.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then high with in_valid=0 → out_valid=0, in_ready=1, RdE=0, CtrlE=0 on every cycle.
- Streaming: out_ready=1; send PCD=0x100,0x104,0x108 on consecutive cycles → PCE shows 0x100,0x104,0x108 one cycle after each accept, with out_valid continuously 1.
- Back-pressure: FULL holding PCD=0x200; drop out_ready and send 0x204 → SKID, in_ready=0 next cycle, PCE holds 0x200. Raise out_ready → 0x200 then 0x204 delivered in order, and in_ready returns to 1.
- Flush in SKID: entries 0x300/0x304 held, assert flush with in_valid=1 carrying PCD=0x308 → next cycle out_valid=0, RdE=0, in_ready=1. 0x308 never appears.
- Async reset mid-stream: assert rst_n=0 between clock edges while FULL → out_valid falls to 0 without waiting for clk. After release, the first accepted bundle (RdD=5'd7) appears with RdE=7.
- Random valid/ready/flush for 10k cycles against a scoreboard queue → no loss, duplication or reordering except the entries each flush removes.

Source files
------------

// File: rtl/pipe_reg_de_elastic.sv
// Decode->Execute pipeline register: 2-entry elastic stage (main + skid) with synchronous flush.
// One-cycle latency; in_ready is a flop (skid empty), so out_ready never reaches in_ready combinationally.
module pipe_reg_de_elastic #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CTRL_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] RD1D,
   input  logic [DATA_WIDTH-1:0] RD2D,
   input  logic [DATA_WIDTH-1:0] PCD,
   input  logic [DATA_WIDTH-1:0] ImmExtD,
   input  logic [DATA_WIDTH-1:0] PCPlus4D,
   input  logic [ADDR_WIDTH-1:0] RdD,
   input  logic [CTRL_WIDTH-1:0] CtrlD,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] RD1E,
   output logic [DATA_WIDTH-1:0] RD2E,
   output logic [DATA_WIDTH-1:0] PCE,
   output logic [DATA_WIDTH-1:0] ImmExtE,
   output logic [DATA_WIDTH-1:0] PCPlus4E,
   output logic [ADDR_WIDTH-1:0] RdE,
   output logic [CTRL_WIDTH-1:0] CtrlE
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] rd1;
      logic [DATA_WIDTH-1:0] rd2;
      logic [DATA_WIDTH-1:0] pc;
      logic [DATA_WIDTH-1:0] imm;
      logic [DATA_WIDTH-1:0] pc4;
      logic [ADDR_WIDTH-1:0] rd;
      logic [CTRL_WIDTH-1:0] ctrl;
   } de_bundle_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_in_ready;
   de_bundle_t r_main;
   de_bundle_t r_skid;
   de_bundle_t w_in;
   logic       w_out_valid;
   logic       w_in_fire;
   logic       w_out_fire;
   logic       w_ld_main_in;
   logic       w_ld_main_skid;
   logic       w_ld_skid;

   assign w_in        = '{rd1: RD1D, rd2: RD2D, pc: PCD, imm: ImmExtD,
                          pc4: PCPlus4D, rd: RdD, ctrl: CtrlD};
   assign w_out_valid = (r_state != ST_EMPTY);
   assign w_in_fire   = in_valid & r_in_ready;
   assign w_out_fire  = w_out_valid & out_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      if (flush) begin
         w_state_nxt = ST_EMPTY;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt  = ST_FULL;
                  w_ld_main_in = 1'b1;
               end
            end
            ST_FULL: begin
               if (w_in_fire && out_ready) begin
                  w_ld_main_in = 1'b1;
               end else if (w_in_fire) begin
                  w_state_nxt = ST_SKID;
                  w_ld_skid   = 1'b1;
               end else if (out_ready) begin
                  w_state_nxt = ST_EMPTY;
               end
            end
            ST_SKID: begin
               // Older skid entry moves up; no new input can land this cycle.
               if (out_ready) begin
                  w_state_nxt    = ST_FULL;
                  w_ld_main_skid = 1'b1;
               end
            end
            default: w_state_nxt = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_EMPTY;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_SKID);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_ld_main_in) begin
            r_main <= w_in;
         end else if (w_ld_main_skid) begin
            r_main <= r_skid;
         end
         if (w_ld_skid) begin
            r_skid <= w_in;
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_out_valid;
   assign RD1E      = r_main.rd1;
   assign RD2E      = r_main.rd2;
   assign PCE       = r_main.pc;
   assign ImmExtE   = r_main.imm;
   assign PCPlus4E  = r_main.pc4;
   // Bubbles must show no destination and no write-enable to the hazard unit.
   assign RdE       = w_out_valid ? r_main.rd   : '0;
   assign CtrlE     = w_out_valid ? r_main.ctrl : '0;

   a_skid_only_when_stalled: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_FULL && w_state_nxt == ST_SKID) |-> !out_ready);

   a_no_accept_in_skid: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_SKID) |-> !w_in_fire);

   a_valid_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (w_out_valid && !w_out_fire && !flush) |=> w_out_valid);

endmodule

// File: tb/tb_pipe_reg_de_elastic.sv
// Bench for pipe_reg_de_elastic: directed scenarios then random traffic against a 2-deep queue model.
module tb_pipe_reg_de_elastic;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 16;

   typedef struct packed {
      logic [DW-1:0] rd1;
      logic [DW-1:0] rd2;
      logic [DW-1:0] pc;
      logic [DW-1:0] imm;
      logic [DW-1:0] pc4;
      logic [AW-1:0] rd;
      logic [CW-1:0] ctrl;
   } bundle_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   bundle_t       din;
   logic [DW-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
   logic [AW-1:0] RdE;
   logic [CW-1:0] CtrlE;
   bundle_t       dout;

   assign dout = '{rd1: RD1E, rd2: RD2E, pc: PCE, imm: ImmExtE, pc4: PCPlus4E, rd: RdE, ctrl: CtrlE};

   pipe_reg_de_elastic #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CTRL_WIDTH(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .RD1D     (din.rd1),
      .RD2D     (din.rd2),
      .PCD      (din.pc),
      .ImmExtD  (din.imm),
      .PCPlus4D (din.pc4),
      .RdD      (din.rd),
      .CtrlD    (din.ctrl),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .RD1E     (RD1E),
      .RD2E     (RD2E),
      .PCE      (PCE),
      .ImmExtE  (ImmExtE),
      .PCPlus4E (PCPlus4E),
      .RdE      (RdE),
      .CtrlE    (CtrlE)
   );

   int      checks = 0;
   int      errors = 0;
   bundle_t model_q[$];

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The stage is a 2-deep FIFO: valid while non-empty, ready while it has a free slot.
   task automatic check_model(input string tag);
      check({tag, "/out_valid"}, out_valid, model_q.size() != 0);
      check({tag, "/in_ready"}, in_ready, model_q.size() < 2);
      if (model_q.size() != 0) begin
         check({tag, "/payload"}, dout, model_q[0]);
      end else begin
         check({tag, "/bubble_rd"}, RdE, '0);
         check({tag, "/bubble_ctrl"}, CtrlE, '0);
      end
   endtask

   function automatic bundle_t mk(input logic [DW-1:0] pc, input logic [AW-1:0] rd);
      bundle_t b;
      b.rd1  = $urandom;
      b.rd2  = $urandom;
      b.pc   = pc;
      b.imm  = $urandom;
      b.pc4  = pc + 32'd4;
      b.rd   = rd;
      b.ctrl = CW'($urandom);
      return b;
   endfunction

   // Called at a negedge: drive one cycle of inputs, advance the model at the edge, check at the next negedge.
   task automatic cycle(input string tag, input logic iv, input logic ordy, input logic fl, input bundle_t b);
      bit inf;
      bit outf;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      din       = b;
      inf  = iv && (model_q.size() < 2);
      outf = (model_q.size() != 0) && ordy;
      @(posedge clk);
      if (fl) begin
         model_q.delete();
      end else begin
         if (outf) void'(model_q.pop_front());
         if (inf) model_q.push_back(b);
      end
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      bundle_t idle_b;
      idle_b    = '0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;

      // Reset then idle
      repeat (2) begin
         @(negedge clk);
         check("rst/out_valid", out_valid, 1'b0);
         check("rst/in_ready", in_ready, 1'b1);
         check("rst/rd", RdE, '0);
         check("rst/ctrl", CtrlE, '0);
         check("rst/no_x", $isunknown(dout), 1'b0);
      end
      rst_n = 1'b1;
      repeat (3) cycle("idle", 1'b0, 1'b1, 1'b0, idle_b);

      // Streaming at full rate
      cycle("stream0", 1'b1, 1'b1, 1'b0, mk(32'h100, 5'd1));
      check("stream0/pc", PCE, 32'h100);
      cycle("stream1", 1'b1, 1'b1, 1'b0, mk(32'h104, 5'd2));
      check("stream1/pc", PCE, 32'h104);
      cycle("stream2", 1'b1, 1'b1, 1'b0, mk(32'h108, 5'd3));
      check("stream2/pc", PCE, 32'h108);
      check("stream2/valid", out_valid, 1'b1);
      cycle("stream_drain", 1'b0, 1'b1, 1'b0, idle_b);

      // Back-pressure into the skid entry
      cycle("bp_fill", 1'b1, 1'b1, 1'b0, mk(32'h200, 5'd4));
      cycle("bp_skid", 1'b1, 1'b0, 1'b0, mk(32'h204, 5'd5));
      check("bp_skid/in_ready", in_ready, 1'b0);
      check("bp_skid/pc", PCE, 32'h200);
      cycle("bp_hold", 1'b1, 1'b0, 1'b0, mk(32'h2FC, 5'd6));
      check("bp_hold/pc", PCE, 32'h200);
      cycle("bp_rel0", 1'b0, 1'b1, 1'b0, idle_b);
      check("bp_rel0/pc", PCE, 32'h204);
      check("bp_rel0/in_ready", in_ready, 1'b1);
      cycle("bp_rel1", 1'b0, 1'b1, 1'b0, idle_b);

      // Flush while both entries are held; the concurrent input is dropped
      cycle("fl_a", 1'b1, 1'b0, 1'b0, mk(32'h300, 5'd8));
      cycle("fl_b", 1'b1, 1'b0, 1'b0, mk(32'h304, 5'd9));
      cycle("fl_go", 1'b1, 1'b0, 1'b1, mk(32'h308, 5'd10));
      check("fl_go/valid", out_valid, 1'b0);
      check("fl_go/rd", RdE, '0);
      check("fl_go/in_ready", in_ready, 1'b1);
      repeat (2) cycle("fl_after", 1'b0, 1'b1, 1'b0, idle_b);

      // Asynchronous reset between edges while FULL
      cycle("ar_fill", 1'b1, 1'b0, 1'b0, mk(32'h400, 5'd11));
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("ar/valid", out_valid, 1'b0);
      check("ar/in_ready", in_ready, 1'b1);
      check("ar/rd", RdE, '0);
      model_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cycle("ar_first", 1'b1, 1'b0, 1'b0, mk(32'h500, 5'd7));
      check("ar_first/rd", RdE, 5'd7);
      cycle("ar_drain", 1'b0, 1'b1, 1'b0, idle_b);

      // Random valid/ready/flush traffic
      for (int i = 0; i < 10000; i++) begin
         cycle("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 31) == 0), mk($urandom, AW'($urandom)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
